pmem_arbiter: RTL

Arbitrates the single physical-memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write).
- Owns one outstanding transaction at a time and sequences issue → wait → response on the memory side.
- Routes each response back to the requester that issued it.
- Sits between IFU/LSU and the pmem wrapper that performs the DPI paddr_read/paddr_write calls.

---
 rtl/pmem_arbiter_pkg.sv | 17 +
 rtl/pmem_arb_pick.sv | 35 +++
 rtl/pmem_arbiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/pmem_arbiter_pkg.sv
// Shared widths, FSM state encoding and owner encoding for the pmem arbiter.
package pmem_arbiter_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;
endpackage

// File: rtl/pmem_arb_pick.sv
// Owner selection between IFU and LSU. With PMEM_ARB_RR_EN defined, ties alternate
// via a last_owner register; otherwise LSU always wins a tie.
module pmem_arb_pick
  import pmem_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_ifu_req,
  input  logic   i_lsu_req,
  input  logic   i_take,
  output logic   o_any,
  output owner_e o_owner
);
  assign o_any = i_ifu_req | i_lsu_req;

`ifdef PMEM_ARB_RR_EN
  owner_e r_last;

  // Resetting to LSU makes the IFU win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_last <= OWN_LSU;
    else if (i_take) r_last <= o_owner;
  end

  always_comb begin
    o_owner = i_lsu_req ? OWN_LSU : OWN_IFU;
    if (i_ifu_req && i_lsu_req) o_owner = (r_last == OWN_LSU) ? OWN_IFU : OWN_LSU;
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, clk, rst_n, i_take};

  always_comb o_owner = i_lsu_req ? OWN_LSU : OWN_IFU;
`endif
endmodule

// File: rtl/pmem_arbiter.sv
// Single-outstanding arbiter of the physical-memory port between IFU and LSU.
// Optional round-robin tie-break via PMEM_ARB_RR_EN (see pmem_arb_pick).
module pmem_arbiter #(
  parameter int ADDR_WIDTH = pmem_arbiter_pkg::ADDR_WIDTH,
  parameter int DATA_WIDTH = pmem_arbiter_pkg::DATA_WIDTH,
  parameter int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifu_req_i,
  input  logic [ADDR_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_gnt_o,
  output logic                  ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic [MASK_WIDTH-1:0] lsu_wmask_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [MASK_WIDTH-1:0] mem_wmask_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  import pmem_arbiter_pkg::*;

  state_e                r_state, w_state_nxt;
  owner_e                r_owner, w_pick;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [MASK_WIDTH-1:0] r_wmask;
  logic                  r_ifu_rvalid, r_lsu_rvalid;
  logic [DATA_WIDTH-1:0] r_ifu_rdata, r_lsu_rdata;
  logic                  w_any, w_take, w_resp, w_ifu_gnt, w_lsu_gnt;

  pmem_arb_pick u_pick (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ifu_req (ifu_req_i),
    .i_lsu_req (lsu_req_i),
    .i_take    (w_take),
    .o_any     (w_any),
    .o_owner   (w_pick)
  );

  // Grants are combinational; gating with rst_n keeps them low while reset is held.
  assign w_take = (r_state == IDLE) && w_any && rst_n;
  assign w_resp = (r_state == WAIT) && mem_rvalid_i;

  always_comb begin
    w_state_nxt = r_state;
    w_ifu_gnt   = 1'b0;
    w_lsu_gnt   = 1'b0;
    unique case (r_state)
      IDLE: if (w_take) begin
        w_state_nxt = ISSUE;
        w_ifu_gnt   = (w_pick == OWN_IFU);
        w_lsu_gnt   = (w_pick == OWN_LSU);
      end
      ISSUE:   if (mem_gnt_i) w_state_nxt = WAIT;
      WAIT:    if (mem_rvalid_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner      <= OWN_IFU;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wmask      <= '0;
      r_ifu_rvalid <= 1'b0;
      r_lsu_rvalid <= 1'b0;
      r_ifu_rdata  <= '0;
      r_lsu_rdata  <= '0;
    end else begin
      if (w_take) begin
        r_owner <= w_pick;
        r_we    <= (w_pick == OWN_LSU) && lsu_we_i;
        r_addr  <= (w_pick == OWN_LSU) ? lsu_addr_i : ifu_addr_i;
        r_wdata <= (w_pick == OWN_LSU) ? lsu_wdata_i : '0;
        r_wmask <= (w_pick == OWN_LSU) ? lsu_wmask_i : '0;
      end
      r_ifu_rvalid <= w_resp && (r_owner == OWN_IFU);
      r_lsu_rvalid <= w_resp && (r_owner == OWN_LSU);
      if (w_resp && r_owner == OWN_IFU)          r_ifu_rdata <= mem_rdata_i;
      if (w_resp && r_owner == OWN_LSU && !r_we) r_lsu_rdata <= mem_rdata_i;
    end
  end

  assign ifu_gnt_o    = w_ifu_gnt;
  assign lsu_gnt_o    = w_lsu_gnt;
  assign ifu_rvalid_o = r_ifu_rvalid;
  assign lsu_rvalid_o = r_lsu_rvalid;
  assign ifu_rdata_o  = r_ifu_rdata;
  assign lsu_rdata_o  = r_lsu_rdata;
  assign mem_req_o    = (r_state == ISSUE);
  assign mem_we_o     = r_we;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  assign mem_wmask_o  = r_wmask;
endmodule
